fc_weight_loader: RTL and testbench
===================================

FC_WEIGHT_LOADER -- requirements
Module: fc_weight_loader

Interface
REQ-001 SHALL provide parameter FC_IN, default 26, meaning FC input length and weight-address range 0..FC_IN-1.
REQ-002 SHALL provide parameter FC_OUT, default 10, meaning FC output count.
REQ-003 SHALL provide parameter W_WIDTH, default 8, meaning signed weight/bias byte width.
REQ-004 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_s_valid  input  1  load-stream beat valid.
REQ-007 SHALL have port o_s_ready  output  1  load-stream beat accepted when valid and ready are both high.
REQ-008 SHALL have port i_s_data  input  W_WIDTH  load-stream byte.
REQ-009 SHALL have port i_s_last  input  1  marks final beat of a frame.
REQ-010 SHALL have port i_lock  input  1  consumer busy; loading is frozen while high.
REQ-011 SHALL have port i_fc_weight_addr  input  5  row address from the conv/FC datapath.
REQ-012 SHALL have port o_fc_weight  output  [FC_IN][FC_OUT] x W_WIDTH  full stored weight array.
REQ-013 SHALL have port o_fc_row  output  [FC_OUT] x W_WIDTH  registered row at i_fc_weight_addr.
REQ-014 SHALL have port o_fc_bias  output  [FC_OUT] x W_WIDTH  stored biases.
REQ-015 SHALL have port o_loaded  output  1  array and biases complete and valid.
REQ-016 SHALL have port o_err  output  1  sticky framing error.

Function
REQ-017 SHALL implement states LOAD_W, LOAD_B, DONE, ERR.
REQ-018 SHALL drive o_s_ready = !i_lock in LOAD_W and LOAD_B, and 0 in DONE and ERR.
REQ-019 SHALL store frame byte k (k < FC_IN*FC_OUT) in weight[k/FC_OUT][k%FC_OUT]; ordering is row-major, address-row first.
REQ-020 SHALL use a col counter (0..FC_OUT-1) and a row counter (0..FC_IN-1); col wraps to 0 and row increments on each accepted beat with col==FC_OUT-1.
REQ-021 SHALL transition LOAD_W->LOAD_B on the accepted beat with row==FC_IN-1 and col==FC_OUT-1.
REQ-022 SHALL store the next FC_OUT bytes in bias[0..FC_OUT-1] in LOAD_B.
REQ-023 SHALL transition LOAD_B->DONE and set o_loaded the cycle after the accepted beat with bias index FC_OUT-1 and i_s_last=1.
REQ-024 SHALL enter ERR and set o_err if i_s_last=1 is accepted before the final bias beat, or if the final bias beat is accepted with i_s_last=0.
REQ-025 SHALL retain all data written before the error while in ERR; o_loaded SHALL stay 0.
REQ-026 SHALL leave DONE or ERR only by reset.
REQ-027 SHALL not change counters or storage in a cycle where i_s_valid is high and o_s_ready is low.
REQ-028 SHALL update o_fc_row one cycle after i_fc_weight_addr is sampled, with read latency 1, independent of state.
REQ-029 SHALL drive o_fc_row to all zeros when i_fc_weight_addr >= FC_IN.
REQ-030 SHALL make o_fc_weight and o_fc_bias direct register outputs with zero latency after each write.
REQ-031 SHALL make an i_lock rise take effect on o_s_ready in the same cycle; no beat is accepted while i_lock=1.

Reset
REQ-032 SHALL on i_rst set state=LOAD_W, row=col=bias index=0, o_loaded=0, o_err=0, o_fc_row=0, and all weight and bias storage to 0.
REQ-033 SHALL give a mid-frame reset priority over a simultaneous accepted beat, discard the partial frame, and restart the load at k=0.

Structure
REQ-034 SHALL place FC_IN, FC_OUT, W_WIDTH defaults and the state enum typedef in shared package conv_fc_pkg.
REQ-035 SHALL have no sub-module; the storage array, counters and FSM are contained in a single module.

Verification
REQ-036 SHALL verify a full frame of bytes 1..260 followed by biases 0xF6..0xFF, with last on beat 270 -> o_loaded=1; weight[3][7]=38; bias[0]=0xF6.
REQ-037 SHALL verify address sweep 0..25 after load -> o_fc_row equals row r one cycle later; address 30 -> all zeros.
REQ-038 SHALL verify i_lock held high for 5 cycles mid-frame with i_s_valid=1 -> o_s_ready=0, no beats lost, and the final array is identical to the unlocked run.
REQ-039 SHALL verify i_s_last on beat 100 -> o_err=1, o_loaded=0, o_s_ready=0 until reset.
REQ-040 SHALL verify reset at beat 150 followed by a new full frame -> final array matches the new frame only.
REQ-041 SHALL verify random i_s_valid gaps (50% duty) on a full frame -> result identical to the back-to-back run.

Source files
------------

// File: rtl/conv_fc_pkg.sv
// Shared defaults and types for the conv/FC datapath: FC geometry, weight width
// and the weight-loader state encoding.
package conv_fc_pkg;

  localparam int unsigned FcInDef   = 26;
  localparam int unsigned FcOutDef  = 10;
  localparam int unsigned WWidthDef = 8;

  typedef enum logic [1:0] {
    LOAD_W = 2'd0,
    LOAD_B = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } load_state_e;

  // Counter width for an index range 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_weight_loader_if.sv
// Byte load stream (valid/ready/last) plus the consumer lock that freezes loading.
interface fc_weight_loader_if #(
  parameter int unsigned W_WIDTH = conv_fc_pkg::WWidthDef
);

  logic               i_s_valid;
  logic               o_s_ready;
  logic [W_WIDTH-1:0] i_s_data;
  logic               i_s_last;
  logic               i_lock;

  modport master (
    output i_s_valid,
    output i_s_data,
    output i_s_last,
    output i_lock,
    input  o_s_ready
  );

  modport slave (
    input  i_s_valid,
    input  i_s_data,
    input  i_s_last,
    input  i_lock,
    output o_s_ready
  );

endinterface

// File: rtl/fc_weight_loader.sv
// Loads a row-major FC weight array followed by FC_OUT biases from a byte stream,
// checks frame length against the last marker, and serves one registered row.
module fc_weight_loader
  import conv_fc_pkg::*;
#(
  parameter int unsigned FC_IN   = FcInDef,
  parameter int unsigned FC_OUT  = FcOutDef,
  parameter int unsigned W_WIDTH = WWidthDef
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  fc_weight_loader_if.slave                        s_if,
  input  logic [4:0]                               i_fc_weight_addr,
  output logic [FC_IN-1:0][FC_OUT-1:0][W_WIDTH-1:0] o_fc_weight,
  output logic [FC_OUT-1:0][W_WIDTH-1:0]            o_fc_row,
  output logic [FC_OUT-1:0][W_WIDTH-1:0]            o_fc_bias,
  output logic                                     o_loaded,
  output logic                                     o_err
);

  localparam int unsigned RowW = idx_width(FC_IN);
  localparam int unsigned ColW = idx_width(FC_OUT);
  localparam logic [RowW-1:0] RowLast = RowW'(FC_IN - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(FC_OUT - 1);

  load_state_e                             state_q, state_d;
  logic [RowW-1:0]                         row_q, row_d;
  logic [ColW-1:0]                         col_q, col_d;
  logic [ColW-1:0]                         bidx_q, bidx_d;
  logic [FC_IN-1:0][FC_OUT-1:0][W_WIDTH-1:0] weight_q, weight_d;
  logic [FC_OUT-1:0][W_WIDTH-1:0]          bias_q, bias_d;
  logic [FC_OUT-1:0][W_WIDTH-1:0]          fc_row_q, fc_row_d;

  logic ready;
  logic accept;
  logic bias_final;

  always_comb begin
    ready  = !s_if.i_lock && ((state_q == LOAD_W) || (state_q == LOAD_B));
    accept = s_if.i_s_valid && ready;
  end

  assign s_if.o_s_ready = ready;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    bidx_d     = bidx_q;
    weight_d   = weight_q;
    bias_d     = bias_q;
    bias_final = (bidx_q == ColLast);
    if (accept) begin
      unique case (state_q)
        LOAD_W: begin
          // A last marker anywhere in the weight section is a short frame.
          if (s_if.i_s_last) begin
            state_d = ERR;
          end else begin
            weight_d[row_q][col_q] = s_if.i_s_data;
            if (col_q == ColLast) begin
              col_d = '0;
              if (row_q == RowLast) begin
                state_d = LOAD_B;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          // Last must coincide exactly with the final bias byte.
          if (bias_final != s_if.i_s_last) begin
            state_d = ERR;
          end else begin
            bias_d[bidx_q] = s_if.i_s_data;
            if (bias_final) begin
              state_d = DONE;
            end else begin
              bidx_d = bidx_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fc_row_d = '0;
    if (32'(i_fc_weight_addr) < FC_IN) begin
      fc_row_d = weight_q[i_fc_weight_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= LOAD_W;
      row_q    <= '0;
      col_q    <= '0;
      bidx_q   <= '0;
      weight_q <= '0;
      bias_q   <= '0;
      fc_row_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      bidx_q   <= bidx_d;
      weight_q <= weight_d;
      bias_q   <= bias_d;
      fc_row_q <= fc_row_d;
    end
  end

  assign o_fc_weight = weight_q;
  assign o_fc_bias   = bias_q;
  assign o_fc_row    = fc_row_q;
  assign o_loaded    = (state_q == DONE);
  assign o_err       = (state_q == ERR);

endmodule

// File: tb/tb_fc_weight_loader.sv
// Self-checking bench for fc_weight_loader: spot-value table, array model built
// from frame byte k -> weight[k/FC_OUT][k%FC_OUT], and multi-cycle corner sequences.
module tb_fc_weight_loader;

  localparam int FC_IN  = 26;
  localparam int FC_OUT = 10;
  localparam int W      = 8;
  localparam int NW     = FC_IN * FC_OUT;
  localparam int NB     = NW + FC_OUT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_weight_loader_if #(.W_WIDTH(W)) s_if ();

  logic [4:0]                          addr;
  logic [FC_IN-1:0][FC_OUT-1:0][W-1:0] fc_weight;
  logic [FC_OUT-1:0][W-1:0]            fc_row;
  logic [FC_OUT-1:0][W-1:0]            fc_bias;
  logic                                loaded;
  logic                                err;

  fc_weight_loader #(
    .FC_IN  (FC_IN),
    .FC_OUT (FC_OUT),
    .W_WIDTH(W)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .s_if            (s_if),
    .i_fc_weight_addr(addr),
    .o_fc_weight     (fc_weight),
    .o_fc_row        (fc_row),
    .o_fc_bias       (fc_bias),
    .o_loaded        (loaded),
    .o_err           (err)
  );

  int checks = 0;
  int errors = 0;
  int lock_cycles;

  logic [W-1:0] frame [NB];
  logic [W-1:0] ref_w [FC_IN][FC_OUT];
  logic [W-1:0] ref_b [FC_OUT];

  typedef struct {
    bit          is_bias;
    int          r;
    int          c;
    logic [7:0]  exp;
  } spot_t;

  spot_t spots [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference contents after the first n frame bytes have been stored.
  task automatic build_ref(input int n);
    for (int r = 0; r < FC_IN; r++)
      for (int c = 0; c < FC_OUT; c++) ref_w[r][c] = '0;
    for (int b = 0; b < FC_OUT; b++) ref_b[b] = '0;
    for (int k = 0; k < n; k++) begin
      if (k < NW) ref_w[k / FC_OUT][k % FC_OUT] = frame[k];
      else        ref_b[k - NW] = frame[k];
    end
  endtask

  task automatic check_array(input string name, input int nprefix);
    int bad = 0;
    for (int k = 0; k < NW && k < nprefix; k++)
      if (fc_weight[k / FC_OUT][k % FC_OUT] !== ref_w[k / FC_OUT][k % FC_OUT]) bad++;
    if (nprefix >= NB)
      for (int b = 0; b < FC_OUT; b++) if (fc_bias[b] !== ref_b[b]) bad++;
    check(name, bad, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_if.i_s_valid = 1'b0;
    s_if.i_s_last  = 1'b0;
    s_if.i_lock    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Streams frame[start .. start+nbeats-1]; last is raised on absolute index last_at.
  task automatic send(input int start, input int nbeats, input int last_at, input int gap_pct,
                      input int lock_start, input int lock_len);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    lock_cycles = 0;
    while (sent < nbeats && cyc < 2000) begin
      @(negedge clk);
      s_if.i_lock    = (cyc >= lock_start) && (cyc < lock_start + lock_len);
      s_if.i_s_valid = s_if.i_lock || ($urandom_range(99) >= gap_pct);
      s_if.i_s_data  = frame[start + sent];
      s_if.i_s_last  = ((start + sent) == last_at);
      #1;
      if (s_if.i_lock) begin
        lock_cycles++;
        check("ready_low_while_locked", int'(s_if.o_s_ready), 0);
      end
      acc = s_if.i_s_valid && s_if.o_s_ready;
      @(posedge clk);
      if (acc) sent++;
      cyc++;
    end
    @(negedge clk);
    s_if.i_s_valid = 1'b0;
    s_if.i_s_last  = 1'b0;
    s_if.i_lock    = 1'b0;
    if (sent < nbeats) check("send_budget", sent, nbeats);
  endtask

  task automatic fill_counting();
    for (int k = 0; k < NW; k++) frame[k] = W'(k + 1);
    for (int b = 0; b < FC_OUT; b++) frame[NW + b] = W'(8'hF6 + b);
  endtask

  initial begin
    logic [FC_OUT-1:0][W-1:0] exp_row;
    logic [7:0] got;

    rst = 1'b1;
    addr = '0;
    s_if.i_s_valid = 1'b0;
    s_if.i_s_data  = '0;
    s_if.i_s_last  = 1'b0;
    s_if.i_lock    = 1'b0;
    spots[0] = '{1'b0, 3, 7, 8'd38};
    spots[1] = '{1'b0, 0, 0, 8'd1};
    spots[2] = '{1'b0, 25, 9, 8'h04};
    spots[3] = '{1'b0, 12, 5, 8'd126};
    spots[4] = '{1'b1, 0, 0, 8'hF6};
    spots[5] = '{1'b1, 0, 9, 8'hFF};
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    check("reset_loaded", int'(loaded), 0);
    check("reset_err", int'(err), 0);
    check("reset_row", int'(fc_row == '0), 1);
    check("reset_ready", int'(s_if.o_s_ready), 1);
    build_ref(0);
    check_array("reset_array", NB);

    // Full counting frame, final beat sent separately to observe load timing
    fill_counting();
    send(0, NB - 1, NB - 1, 0, -100, 0);
    check("loaded_before_final", int'(loaded), 0);
    check("ready_before_final", int'(s_if.o_s_ready), 1);
    send(NB - 1, 1, NB - 1, 0, -100, 0);
    check("loaded_after_final", int'(loaded), 1);
    check("err_after_final", int'(err), 0);
    check("ready_in_done", int'(s_if.o_s_ready), 0);
    for (int i = 0; i < 6; i++) begin
      got = spots[i].is_bias ? fc_bias[spots[i].c] : fc_weight[spots[i].r][spots[i].c];
      check($sformatf("spot_%0d", i), int'(got), int'(spots[i].exp));
    end
    build_ref(NB);
    check_array("full_frame_array", NB);

    // Address sweep, out-of-range address and read latency
    for (int r = 0; r < FC_IN; r++) begin
      @(negedge clk);
      addr = 5'(r);
      @(negedge clk);
      for (int c = 0; c < FC_OUT; c++) exp_row[c] = ref_w[r][c];
      check($sformatf("row_%0d", r), int'(fc_row == exp_row), 1);
    end
    @(negedge clk);
    addr = 5'd30;
    @(negedge clk);
    check("row_addr30_zero", int'(fc_row == '0), 1);
    addr = 5'd5;
    #1;
    check("row_latency_hold", int'(fc_row == '0), 1);
    @(negedge clk);
    for (int c = 0; c < FC_OUT; c++) exp_row[c] = ref_w[5][c];
    check("row_latency_update", int'(fc_row == exp_row), 1);

    // Lock for 5 cycles mid-frame with valid held high
    do_reset();
    send(0, NB, NB - 1, 0, 50, 5);
    check("lock_cycles", lock_cycles, 5);
    check("lock_loaded", int'(loaded), 1);
    check_array("lock_array", NB);

    // Early last on beat 100
    do_reset();
    send(0, 100, 99, 0, -100, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_if.i_s_valid = 1'b1;
      #1;
      check("err_sticky", int'(err), 1);
      check("err_not_loaded", int'(loaded), 0);
      check("err_ready_low", int'(s_if.o_s_ready), 0);
    end
    s_if.i_s_valid = 1'b0;
    build_ref(99);
    check_array("err_retained", 99);
    do_reset();
    #1;
    check("err_cleared_by_reset", int'(err), 0);

    // Missing last on the final bias beat
    send(0, NB, -1, 0, -100, 0);
    check("no_last_err", int'(err), 1);
    check("no_last_not_loaded", int'(loaded), 0);

    // Reset at beat 150 coinciding with a valid beat, then a new random frame
    do_reset();
    send(0, 149, -1, 0, -100, 0);
    @(negedge clk);
    s_if.i_s_valid = 1'b1;
    s_if.i_s_data  = frame[149];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_if.i_s_valid = 1'b0;
    build_ref(0);
    check_array("midreset_cleared", NB);
    check("midreset_ready", int'(s_if.o_s_ready), 1);
    for (int k = 0; k < NB; k++) frame[k] = W'($urandom);
    send(0, NB, NB - 1, 0, -100, 0);
    build_ref(NB);
    check("midreset_loaded", int'(loaded), 1);
    check_array("midreset_new_frame", NB);

    // 50% valid gaps on the counting frame
    fill_counting();
    build_ref(NB);
    do_reset();
    send(0, NB, NB - 1, 50, -100, 0);
    check("gaps_loaded", int'(loaded), 1);
    check_array("gaps_array", NB);

    // Random frames, random gaps and random lock windows
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < NB; k++) frame[k] = W'($urandom);
      build_ref(NB);
      do_reset();
      send(0, NB, NB - 1, int'($urandom_range(70)), int'($urandom_range(200)),
           int'($urandom_range(8)));
      check($sformatf("rand_%0d_loaded", t), int'(loaded), 1);
      check_array($sformatf("rand_%0d_array", t), NB);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
